// File: rtl/jtag_shift_master_if.sv
// Command/response handshake between a host and jtag_shift_master.
interface jtag_shift_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_len;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/jtag_shift_master.sv
// Host-side JTAG driver: runs TAP reset, IR and DR scans from single commands.
// TCK is derived from clk (half-period CLK_DIV cycles). TMS/TDI change at the
// start of each TCK low phase; TDO is captured on the TCK rising edge.
// Optional feature macro JTAG_MASTER_RTI_EN: append RTI_CYCLES Run-Test/Idle
// TCK cycles after every IR/DR scan before responding.
module jtag_shift_master #(
  parameter int unsigned CLK_DIV    = 5,
  parameter int unsigned RTI_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  jtag_shift_master_if.slave  bus,
  output logic                tck,
  output logic                tms,
  output logic                tdi,
  input  logic                tdo
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  // Edge counter also has to hold the Run-Test/Idle tail length.
  localparam int unsigned EDGE_W = ($clog2(RTI_CYCLES + 1) > 6) ? $clog2(RTI_CYCLES + 1) : 6;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_IR    = 2'b01;
  localparam logic [1:0] OP_RSVD  = 2'b11;

`ifdef JTAG_MASTER_RTI_EN
  localparam logic [EDGE_W-1:0] RTI_LAST = EDGE_W'(RTI_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    RESET_SEQ,
    IDLE,
    PRE,
    SHIFT,
    POST,
`ifdef JTAG_MASTER_RTI_EN
    RTI,
`endif
    DONE
  } state_t;

  state_t             state;
  logic [DIV_W-1:0]   div_cnt;
  logic [EDGE_W-1:0]  edge_cnt;
  logic [4:0]         shift_idx;
  logic [4:0]         len_q;
  logic [1:0]         op_q;
  logic [31:0]        data_q;
  logic [31:0]        cap_q;
  logic               seq_rsp;

  logic               div_end;
  logic               accept;
  logic               tck_busy;
  logic [4:0]         shift_nxt;
  logic [EDGE_W-1:0]  pre_last;

  assign div_end   = (div_cnt == DIV_LAST);
  assign accept    = bus.cmd_ready && bus.cmd_valid;
  assign shift_nxt = shift_idx + 5'd1;

  // States that toggle TCK, and the last preamble edge index per scan type.
  always_comb begin
    tck_busy = 1'b0;
    pre_last = (op_q == OP_IR) ? EDGE_W'(3) : EDGE_W'(2);
    case (state)
      RESET_SEQ, PRE, SHIFT, POST: tck_busy = 1'b1;
`ifdef JTAG_MASTER_RTI_EN
      RTI:                         tck_busy = 1'b1;
`endif
      default:                     tck_busy = 1'b0;
    endcase
  end

  // Command FSM, TCK divider and TMS/TDI sequencing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RESET_SEQ;
      div_cnt       <= '0;
      edge_cnt      <= '0;
      shift_idx     <= '0;
      len_q         <= '0;
      op_q          <= OP_RESET;
      data_q        <= '0;
      cap_q         <= '0;
      seq_rsp       <= 1'b0;
      tck           <= 1'b0;
      tms           <= 1'b1;
      tdi           <= 1'b0;
      bus.cmd_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
    end else if (accept) begin
      op_q          <= bus.cmd_op;
      len_q         <= bus.cmd_len;
      data_q        <= bus.cmd_data;
      cap_q         <= '0;
      div_cnt       <= '0;
      edge_cnt      <= '0;
      shift_idx     <= '0;
      tck           <= 1'b0;
      tdi           <= 1'b0;
      bus.cmd_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      case (bus.cmd_op)
        OP_RSVD: begin
          // No TCK activity: answer with zero data on the next cycle.
          state         <= DONE;
          bus.rsp_valid <= 1'b1;
          bus.rsp_data  <= '0;
        end
        OP_RESET: begin
          state   <= RESET_SEQ;
          seq_rsp <= 1'b1;
          tms     <= 1'b1;
        end
        default: begin
          state <= PRE;
          tms   <= 1'b1;
        end
      endcase
    end else if (state == DONE) begin
      state         <= IDLE;
      bus.rsp_valid <= 1'b0;
      bus.cmd_ready <= 1'b1;
    end else if (tck_busy) begin
      if (!div_end) begin
        div_cnt <= div_cnt + 1'b1;
      end else begin
        div_cnt <= '0;
        if (!tck) begin
          // Rising TCK: sample TDO on shift edges.
          tck <= 1'b1;
          if (state == SHIFT) cap_q[shift_idx] <= tdo;
        end else begin
          // Falling TCK: the edge is complete, set up the next one.
          tck <= 1'b0;
          case (state)
            RESET_SEQ: begin
              if (edge_cnt == EDGE_W'(5)) begin
                edge_cnt      <= '0;
                seq_rsp       <= 1'b0;
                bus.cmd_ready <= 1'b1;
                if (seq_rsp) begin
                  state         <= DONE;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_data  <= '0;
                end else begin
                  state <= IDLE;
                end
              end else begin
                edge_cnt <= edge_cnt + 1'b1;
                tms      <= (edge_cnt != EDGE_W'(4));
              end
            end
            PRE: begin
              if (edge_cnt == pre_last) begin
                state    <= SHIFT;
                edge_cnt <= '0;
                tms      <= (len_q == 5'd0);
                tdi      <= data_q[0];
              end else begin
                edge_cnt <= edge_cnt + 1'b1;
                tms      <= (op_q == OP_IR) && (edge_cnt == '0);
              end
            end
            SHIFT: begin
              if (shift_idx == len_q) begin
                state <= POST;
                tms   <= 1'b1;
                tdi   <= 1'b0;
              end else begin
                shift_idx <= shift_nxt;
                tms       <= (shift_nxt == len_q);
                tdi       <= data_q[shift_nxt];
              end
            end
            POST: begin
              if (edge_cnt == '0) begin
                edge_cnt <= EDGE_W'(1);
                tms      <= 1'b0;
              end else begin
                edge_cnt <= '0;
`ifdef JTAG_MASTER_RTI_EN
                if (RTI_CYCLES == 0) begin
                  state         <= DONE;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_data  <= cap_q;
                  bus.cmd_ready <= 1'b1;
                end else begin
                  state <= RTI;
                end
`else
                state         <= DONE;
                bus.rsp_valid <= 1'b1;
                bus.rsp_data  <= cap_q;
                bus.cmd_ready <= 1'b1;
`endif
              end
            end
`ifdef JTAG_MASTER_RTI_EN
            RTI: begin
              if (edge_cnt == RTI_LAST) begin
                edge_cnt      <= '0;
                state         <= DONE;
                bus.rsp_valid <= 1'b1;
                bus.rsp_data  <= cap_q;
                bus.cmd_ready <= 1'b1;
              end else begin
                edge_cnt <= edge_cnt + 1'b1;
              end
            end
`endif
            default: begin
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_shift_master.sv
// Directed bench for jtag_shift_master with a behavioural TAP on the pins.
module tb_jtag_shift_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tck;
  logic tms;
  logic tdi;
  logic tdo = 1'b0;

  jtag_shift_master_if bus ();

  jtag_shift_master #(.CLK_DIV(5), .RTI_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .tck (tck),
    .tms (tms),
    .tdi (tdi),
    .tdo (tdo)
  );

  always #5 clk = ~clk;

`ifdef JTAG_MASTER_RTI_EN
  localparam int R = 2;
`else
  localparam int R = 0;
`endif

  int checks = 0;
  int failures = 0;

  logic tms_q[$];
  logic tdi_q[$];

  // Behavioural TAP: IR captures 0001, instruction 0x4 selects a 32-bit IDCODE.
  localparam int TLR = 0, RTIS = 1, SDR = 2, CDR = 3, SHD = 4, E1D = 5, PDR = 6, E2D = 7;
  localparam int UDR = 8, SIR = 9, CIR = 10, SHI = 11, E1I = 12, PIR = 13, E2I = 14, UIR = 15;
  localparam logic [3:0]  IDC_INSTR = 4'h4;
  localparam logic [31:0] IDCODE    = 32'h1234_5679;

  int          tap_st = TLR;
  logic [3:0]  ir     = IDC_INSTR;
  logic [3:0]  ir_sh  = 4'h0;
  logic [31:0] dr_sh  = 32'h0;

  function automatic int tap_next(input int s, input logic m);
    case (s)
      TLR:     return m ? TLR : RTIS;
      RTIS:    return m ? SDR : RTIS;
      SDR:     return m ? SIR : CDR;
      CDR:     return m ? E1D : SHD;
      SHD:     return m ? E1D : SHD;
      E1D:     return m ? UDR : PDR;
      PDR:     return m ? E2D : PDR;
      E2D:     return m ? UDR : SHD;
      UDR:     return m ? SDR : RTIS;
      SIR:     return m ? TLR : CIR;
      CIR:     return m ? E1I : SHI;
      SHI:     return m ? E1I : SHI;
      E1I:     return m ? UIR : PIR;
      PIR:     return m ? E2I : PIR;
      E2I:     return m ? UIR : SHI;
      default: return m ? SDR : RTIS;
    endcase
  endfunction

  always @(posedge tck) begin
    tms_q.push_back(tms);
    tdi_q.push_back(tdi);
    case (tap_st)
      TLR: ir = IDC_INSTR;
      CIR: ir_sh = 4'b0001;
      SHI: ir_sh = {tdi, ir_sh[3:1]};
      UIR: ir = ir_sh;
      CDR: dr_sh = (ir == IDC_INSTR) ? IDCODE : 32'h0;
      SHD: dr_sh = (ir == IDC_INSTR) ? {tdi, dr_sh[31:1]} : {31'h0, tdi};
      default: ;
    endcase
    tap_st = tap_next(tap_st, tms);
  end

  always @(negedge tck) begin
    tdo = (tap_st == SHI) ? ir_sh[0] : (tap_st == SHD) ? dr_sh[0] : 1'b0;
  end

  function automatic logic [63:0] pack_q(input logic q[$]);
    logic [63:0] v = '0;
    for (int i = 0; i < q.size() && i < 64; i++) v[i] = q[i];
    return v;
  endfunction

  // Drives one command from a ready point; returns CLK cycles from acceptance to RSP_VALID.
  task automatic issue_cmd(input logic [1:0] op, input logic [4:0] len, input logic [31:0] data,
                           output int lat, output logic ready_after);
    tms_q.delete();
    tdi_q.delete();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_len   = len;
    bus.cmd_data  = data;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    ready_after   = bus.cmd_ready;
    lat = -1;
    for (int i = 1; i <= 2000; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    logic saw_rsp;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (tck !== 1'b0) begin failures++; $display("FAIL rst_tck got=%b exp=0", tck); end
    checks++; if (tms !== 1'b1) begin failures++; $display("FAIL rst_tms got=%b exp=1", tms); end
    checks++; if (tdi !== 1'b0) begin failures++; $display("FAIL rst_tdi got=%b exp=0", tdi); end
    checks++; if (bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", bus.cmd_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=0", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 32'h0) begin failures++; $display("FAIL rst_rsp_data got=%h exp=0", bus.rsp_data); end
    @(negedge clk);
    tms_q.delete();
    tdi_q.delete();
    rst = 1'b0;
    n = -1;
    saw_rsp = 1'b0;
    for (int i = 1; i <= 500; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) saw_rsp = 1'b1;
      if (bus.cmd_ready) begin
        n = i;
        break;
      end
    end
    checks++; if (n != 60) begin failures++; $display("FAIL startup_latency got=%0d exp=60", n); end
    checks++; if (tms_q.size() != 6) begin failures++; $display("FAIL startup_edges got=%0d exp=6", tms_q.size()); end
    checks++; if (pack_q(tms_q) !== 64'h1F) begin failures++; $display("FAIL startup_tms got=%h exp=1f", pack_q(tms_q)); end
    checks++; if (saw_rsp !== 1'b0) begin failures++; $display("FAIL startup_no_rsp got=%b exp=0", saw_rsp); end
  endtask

  task automatic test_ir_scan();
    int lat;
    logic rdy;
    issue_cmd(2'b01, 5'd3, 32'h4, lat, rdy);
    checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL ir_ready_drop got=%b exp=0", rdy); end
    checks++; if (lat != 10 * (10 + R)) begin failures++; $display("FAIL ir_latency got=%0d exp=%0d", lat, 10 * (10 + R)); end
    checks++; if (bus.rsp_data !== 32'h1) begin failures++; $display("FAIL ir_rsp_data got=%h exp=1", bus.rsp_data); end
    checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL ir_ready_rise got=%b exp=1", bus.cmd_ready); end
    checks++; if (tms_q.size() != 10 + R) begin failures++; $display("FAIL ir_edges got=%0d exp=%0d", tms_q.size(), 10 + R); end
    checks++; if (pack_q(tms_q) !== 64'h183) begin failures++; $display("FAIL ir_tms got=%h exp=183", pack_q(tms_q)); end
    checks++; if (pack_q(tdi_q) !== 64'h40) begin failures++; $display("FAIL ir_tdi got=%h exp=40", pack_q(tdi_q)); end
  endtask

  task automatic test_dr_idcode();
    int lat;
    logic rdy;
    issue_cmd(2'b10, 5'd31, 32'h0, lat, rdy);
    checks++; if (lat != 10 * (37 + R)) begin failures++; $display("FAIL idcode_latency got=%0d exp=%0d", lat, 10 * (37 + R)); end
    checks++; if (bus.rsp_data !== IDCODE) begin failures++; $display("FAIL idcode_data got=%h exp=%h", bus.rsp_data, IDCODE); end
    checks++; if (tms_q.size() != 37 + R) begin failures++; $display("FAIL idcode_edges got=%0d exp=%0d", tms_q.size(), 37 + R); end
    checks++; if (pack_q(tms_q) !== 64'hC_0000_0001) begin failures++; $display("FAIL idcode_tms got=%h exp=c00000001", pack_q(tms_q)); end
    checks++; if (pack_q(tdi_q) !== 64'h0) begin failures++; $display("FAIL idcode_tdi got=%h exp=0", pack_q(tdi_q)); end
  endtask

  task automatic test_min_dr();
    int lat;
    logic rdy;
    issue_cmd(2'b10, 5'd0, 32'h1, lat, rdy);
    checks++; if (lat != 10 * (6 + R)) begin failures++; $display("FAIL mindr_latency got=%0d exp=%0d", lat, 10 * (6 + R)); end
    checks++; if (bus.rsp_data !== 32'h1) begin failures++; $display("FAIL mindr_data got=%h exp=1", bus.rsp_data); end
    checks++; if (pack_q(tms_q) !== 64'h19) begin failures++; $display("FAIL mindr_tms got=%h exp=19", pack_q(tms_q)); end
    checks++; if (pack_q(tdi_q) !== 64'h08) begin failures++; $display("FAIL mindr_tdi got=%h exp=08", pack_q(tdi_q)); end
  endtask

  task automatic test_tap_reset();
    int lat;
    logic rdy;
    issue_cmd(2'b00, 5'd31, 32'hFFFF_FFFF, lat, rdy);
    checks++; if (lat != 60) begin failures++; $display("FAIL tapreset_latency got=%0d exp=60", lat); end
    checks++; if (bus.rsp_data !== 32'h0) begin failures++; $display("FAIL tapreset_data got=%h exp=0", bus.rsp_data); end
    checks++; if (tms_q.size() != 6) begin failures++; $display("FAIL tapreset_edges got=%0d exp=6", tms_q.size()); end
    checks++; if (pack_q(tms_q) !== 64'h1F) begin failures++; $display("FAIL tapreset_tms got=%h exp=1f", pack_q(tms_q)); end
    checks++; if (pack_q(tdi_q) !== 64'h0) begin failures++; $display("FAIL tapreset_tdi got=%h exp=0", pack_q(tdi_q)); end
  endtask

  task automatic test_back_to_back();
    int n;
    tms_q.delete();
    tdi_q.delete();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b01;
    bus.cmd_len   = 5'd3;
    bus.cmd_data  = 32'h4;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    // Pulse a command while busy; it must be ignored.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b01;
    bus.cmd_len   = 5'd0;
    bus.cmd_data  = 32'h0;
    @(posedge clk); #1;
    checks++; if (bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL busy_ready got=%b exp=0", bus.cmd_ready); end
    // Now hold a reserved command through the response.
    bus.cmd_op   = 2'b11;
    bus.cmd_data = 32'hFFFF_FFFF;
    n = -1;
    for (int i = 32; i <= 2000; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) begin
        n = i;
        break;
      end
    end
    checks++; if (n != 10 * (10 + R)) begin failures++; $display("FAIL busy_latency got=%0d exp=%0d", n, 10 * (10 + R)); end
    checks++; if (bus.rsp_data !== 32'h1) begin failures++; $display("FAIL busy_ir_data got=%h exp=1", bus.rsp_data); end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    checks++; if (bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL rsvd_valid got=%b exp=1", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 32'h0) begin failures++; $display("FAIL rsvd_data got=%h exp=0", bus.rsp_data); end
    checks++; if (bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL rsvd_ready_drop got=%b exp=0", bus.cmd_ready); end
    @(posedge clk); #1;
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL rsvd_pulse_end got=%b exp=0", bus.rsp_valid); end
    checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL rsvd_ready_back got=%b exp=1", bus.cmd_ready); end
    checks++; if (tms_q.size() != 10 + R) begin failures++; $display("FAIL busy_edges got=%0d exp=%0d", tms_q.size(), 10 + R); end
  endtask

  task automatic test_abort();
    int n;
    logic saw_rsp;
    tms_q.delete();
    tdi_q.delete();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b10;
    bus.cmd_len   = 5'd31;
    bus.cmd_data  = 32'h0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    // Shift edge 10 is the 14th rising TCK of a DR scan.
    n = -1;
    for (int i = 1; i <= 1000; i++) begin
      @(posedge clk); #1;
      if (tms_q.size() >= 14) begin
        n = i;
        break;
      end
    end
    checks++; if (n < 0) begin failures++; $display("FAIL abort_reach_edge got=timeout exp=14 edges"); end
    rst = 1'b1;
    #1;
    checks++; if (tck !== 1'b0) begin failures++; $display("FAIL abort_tck got=%b exp=0", tck); end
    checks++; if (tms !== 1'b1) begin failures++; $display("FAIL abort_tms got=%b exp=1", tms); end
    saw_rsp = bus.rsp_valid;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tms_q.delete();
    rst = 1'b0;
    n = -1;
    for (int i = 1; i <= 500; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) saw_rsp = 1'b1;
      if (bus.cmd_ready) begin
        n = i;
        break;
      end
    end
    checks++; if (saw_rsp !== 1'b0) begin failures++; $display("FAIL abort_no_rsp got=%b exp=0", saw_rsp); end
    checks++; if (n != 60) begin failures++; $display("FAIL abort_restart_latency got=%0d exp=60", n); end
    checks++; if (pack_q(tms_q) !== 64'h1F) begin failures++; $display("FAIL abort_restart_tms got=%h exp=1f", pack_q(tms_q)); end
    checks++; if (bus.rsp_data !== 32'h0) begin failures++; $display("FAIL abort_rsp_data got=%h exp=0", bus.rsp_data); end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_len   = 5'd0;
    bus.cmd_data  = 32'h0;
    test_reset();
    test_ir_scan();
    test_dr_idcode();
    test_min_dr();
    test_tap_reset();
    test_back_to_back();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtag_shift_master.md
# jtag_shift_master

Host-side JTAG driver that generates TCK/TMS/TDI from a single system clock and captures TDO, so on-board logic can run the TAP through IR and DR scans instead of a bench or external probe. It sits directly upstream of the board's TAP (the JB_TCK/JB_TMS/JB_TDI/JB_TDO pins) and accepts one scan command at a time over a valid/ready handshake. Scan results, for example the 32-bit IDCODE, are returned on a one-cycle response strobe.

## Interface
- CLK_DIV, 5: TCK half-period in CLK cycles; must be ≥1. TCK period = 2·CLK_DIV CLK cycles.
- RTI_CYCLES, 2: extra Run-Test/Idle TCK cycles appended after each IR/DR scan. Only used when JTAG_MASTER_RTI_EN is defined.
- CLK  in  1  system clock; all logic on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- CMD_VALID  in  1  command request.
- CMD_READY  out  1  block idle and able to accept a command.
- CMD_OP  in  2  operation code:
  - 00: TAP reset
  - 01: IR scan
  - 10: DR scan
  - 11: reserved
- CMD_LEN  in  5  scan length minus 1, giving 1..32 bits.
- CMD_DATA  in  32  bits to shift into TDI, LSB first.
- RSP_VALID  out  1  one-CLK pulse at command completion.
- RSP_DATA  out  32  captured TDO bits, LSB first; held until the next RSP_VALID.
- TCK  out  1  JTAG clock; idles low.
- TMS  out  1  JTAG mode select.
- TDI  out  1  JTAG data to the TAP.
- TDO  in  1  JTAG data from the TAP.

## Operation
- The TAP is tracked as being in Run-Test/Idle between commands.
- **Command acceptance:** a command is accepted on the CLK edge where CMD_VALID && CMD_READY. OP, LEN and DATA are latched on that edge and CMD_READY drops on the next cycle.
- **Per-bit rule:** each TCK cycle consists of a low phase followed by a high phase.
  - TMS and TDI update at the start of the low phase.
  - TDO is sampled at the TCK rising edge.
- **TMS sequences** (one entry per TCK rising edge):
  - Reset (00): 1,1,1,1,1,0. Ends in Run-Test/Idle. LEN and DATA are ignored. RSP_DATA is 0.
  - IR (01): 1,1,0,0, then LEN+1 shift edges, then 1,0.
  - DR (10): 1,0,0, then LEN+1 shift edges, then 1,0.
  - Shift edges: TMS=0 on every shift edge except the last, which has TMS=1 (exit to Exit1).
  - TDI = CMD_DATA[i] on shift edge i. TDI = 0 outside shift edges.
  - RSP_DATA[i] = TDO sampled at shift edge i. Bits above LEN are 0.
- **Reserved (11):** accepted with no TCK activity. RSP_VALID pulses on the next cycle with RSP_DATA = 0.
- **FSM states:** RESET_SEQ, IDLE, PRE (TMS preamble), SHIFT, POST (1,0 postamble), RTI (macro only), DONE.
  - PRE → SHIFT → POST → DONE → IDLE. With the macro, POST goes to RTI before DONE.
- **Start-up:** after RST deasserts, the block automatically runs the reset sequence (RESET_SEQ) before CMD_READY first rises.
- **Busy behaviour:** CMD_VALID while CMD_READY=0 is ignored and has no side effects.
- **Reset mid-operation:** asserting RST at any point aborts the command immediately.
  - No RSP_VALID is produced for the aborted command.
  - The start-up reset sequence repeats after RST release.

## Timing
- **Reset values:** TCK=0, TMS=1, TDI=0, CMD_READY=0, RSP_VALID=0, RSP_DATA=0.
- **First TCK activity:** the first TCK low phase begins the cycle after acceptance, or the cycle after RST release.
- **Scan latency:** a scan of N edges takes 2·CLK_DIV·N CLK cycles.
  - RSP_VALID and CMD_READY both rise in the CLK cycle where the final TCK high phase ends and TCK returns low.
  - A new command can be accepted in that same cycle, so back-to-back commands leave no idle TCK gap.
- **Edge counts:** IR scan = LEN+7 edges; DR scan = LEN+6 edges; TAP reset = 6 edges.
- **Internal counters:**
  - Shift index counter: 5 bits.
  - Edge counter: at least 6 bits.
  - Divider: clog2(CLK_DIV) bits, wrapping at CLK_DIV−1.

## Configuration
- **Macro:** JTAG_MASTER_RTI_EN.
- **Defined:** after the postamble of every IR/DR scan, RTI_CYCLES further TCK cycles are issued with TMS=0 and TDI=0. RSP_VALID is delayed by 2·CLK_DIV·RTI_CYCLES CLK cycles.
- **Undefined:** the RTI state is removed, RTI_CYCLES is ignored, and the response follows the postamble directly.
- Reset (00) and reserved (11) operations are unaffected either way.

## Test plan
- **Start-up:** release RST → TMS=1 on 5 rising TCK edges, then 0 on the 6th. TCK period = 10 CLK. CMD_READY rises 60 CLK after release.
- **IR scan:** OP=01, LEN=3, DATA=0x4 → TMS 1,1,0,0,0,0,0,1,1,0 and TDI 0,0,1,0 on the shift edges. With a TAP model capturing 4'b0001, RSP_DATA=0x1. RSP_VALID comes 100 CLK after acceptance.
- **DR scan (IDCODE):** after the IR scan, OP=10, LEN=31, DATA=0 → RSP_DATA equals the model IDCODE, e.g. 0x1234_5679, after 37 edges.
- **Minimum-length DR:** OP=10, LEN=0, DATA=1 → exactly one shift edge, carrying TMS=1 and TDI=1. RSP_DATA[31:1]=0.
- **Handshake:**
  - Pulse CMD_VALID with OP=01 mid-scan → ignored; CMD_READY stays 0.
  - Hold CMD_VALID with OP=11 through the response → the reserved command is accepted on the RSP_VALID cycle and answered 1 CLK later with data 0.
- **Abort and macro check:**
  - Assert RST during DR shift edge 10 → TCK=0 and TMS=1 immediately. No RSP_VALID. The reset sequence reruns on release.
  - With JTAG_MASTER_RTI_EN defined, the IR scan response moves 20 CLK later.
